reg_access_ctrl: RTL
====================

Name: reg_access_ctrl

Overview:
- Initiator-side controller for the team's single-word register block: drives write_enable/write_data/read_enable and consumes read_data.
- Accepts host commands over a valid/ready channel and sequences the register strobes.
- Captures read data after a fixed read latency and returns one response per command over a valid/ready channel.
- Adds a write-then-verify command and completion/error counters for bring-up and self-test.

Parameters:
- WIDTH, 16, data width of the register and the command/response data.
- RD_LATENCY, 1, cycles from the clock edge sampling read_enable=1 to read_data being valid; legal range 1..7.
- CNT_W, 16, width of the txn_count and err_count counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  controller can accept a command (IDLE only).
- cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 WRITE_VERIFY.
- cmd_data  in  WIDTH  write data for WRITE/WRITE_VERIFY.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  WIDTH  read/readback value; 0 for WRITE.
- rsp_err  out  1  WRITE_VERIFY mismatch flag.
- write_enable  out  1  register write strobe.
- write_data  out  WIDTH  register write data.
- read_enable  out  1  register read strobe.
- read_data  in  WIDTH  register read data.
- txn_count  out  CNT_W  number of responses handshaken.
- err_count  out  CNT_W  number of responses handshaken with rsp_err=1.

Behaviour:
- Reset: state IDLE; cmd_ready=1 after reset deasserts. All other outputs are 0: rsp_valid, rsp_data, rsp_err, write_enable, write_data, read_enable, txn_count, err_count. The internal op and data latches are 0.
- Reset mid-operation: the in-flight command is dropped, with no response. Any asserted strobe drops asynchronously with reset.
- FSM states: IDLE, WR, RD, RD_WAIT, RESP.
- IDLE: cmd_ready=1. The command is accepted on an edge where cmd_valid=1.
  - The controller latches op and cmd_data; write_data <= cmd_data for WRITE/WRITE_VERIFY.
  - Next state: WRITE or WRITE_VERIFY -> WR; READ -> RD; NOP -> stays IDLE (no strobe, no response, counters unchanged).
- WR: write_enable=1 for exactly one cycle. WRITE -> RESP (rsp_data=0, rsp_err=0); WRITE_VERIFY -> RD.
- RD: read_enable=1 for exactly one cycle, then -> RD_WAIT with the wait counter loaded to RD_LATENCY-1.
- RD_WAIT: decrement each cycle. On the edge where the counter is 0:
  - rsp_data <= read_data.
  - For WRITE_VERIFY, rsp_err <= (read_data != write_data); otherwise 0.
  - Next state -> RESP.
- RESP: rsp_valid=1; rsp_data and rsp_err are held stable until handshake.
  - On rsp_valid && rsp_ready: txn_count+1; err_count+1 if rsp_err; -> IDLE.
  - Backpressure is unbounded; no new command is accepted while in RESP.
- Strobes are mutually exclusive; write_enable and read_enable are never high in the same cycle.
- write_data holds its last value outside WR/verify; it is not cleared.
- Latency, with the accept edge at cycle 0:
  - WRITE: write_enable in cycle 1; rsp_valid from cycle 2.
  - READ: read_enable in cycle 1; rsp_valid from cycle 2+RD_LATENCY.
  - WRITE_VERIFY: write_enable in cycle 1; read_enable in cycle 2; rsp_valid from cycle 3+RD_LATENCY.
- Counters wrap modulo 2^CNT_W without saturation.
- One outstanding command only. A new command can be accepted on the cycle after the response handshake, at the earliest.

Decomposition:
- Package reg_access_pkg holds:
  - the op encodings (OP_NOP, OP_WRITE, OP_READ, OP_WRITE_VERIFY);
  - the FSM state typedef;
  - the RD_LATENCY range limit constant.
- No sub-module: the FSM, wait counter and stat counters are a single module. The bench pairs it with the existing register block as the responder.

Test Plan:
- Reset held 2 cycles, then released -> cmd_ready=1, every output 0, counters 0.
- WRITE cmd_data=16'hAAAA accepted at cycle 0 -> write_enable=1 only in cycle 1 with write_data=16'hAAAA; rsp_valid cycle 2, rsp_data=0, rsp_err=0; txn_count=1.
- READ after the write, RD_LATENCY=1 -> read_enable only in cycle 1; rsp_valid cycle 3, rsp_data=16'hAAAA. Repeat with RD_LATENCY=3 -> rsp_valid cycle 5.
- WRITE_VERIFY 16'h1234 against a good register -> rsp_err=0. Against a bench model forcing read_data=16'h1235 -> rsp_err=1, rsp_data=16'h1235, err_count=1.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0 throughout, no strobes; the counters increment only on the handshake cycle.
- Reset asserted during RD_WAIT of a READ -> read_enable/rsp_valid 0 immediately, state IDLE, no response, txn_count unchanged. A NOP accepted afterwards -> no strobe, no response.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared definitions for the register access controller: host op encodings,
// controller FSM states and the read-latency limits.
package reg_access_pkg;

  // Largest supported register read latency; sizes the wait counter.
  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned WAIT_W     = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [1:0] {
    OP_NOP          = 2'b00,
    OP_WRITE        = 2'b01,
    OP_READ         = 2'b10,
    OP_WRITE_VERIFY = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // True for ops that start with a register write strobe.
  function automatic logic op_writes(input op_e op);
    return (op == OP_WRITE) || (op == OP_WRITE_VERIFY);
  endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Host-side command/response channel of the register access controller.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (host -> controller)
//   rsp_valid/rsp_ready/rsp_data/rsp_err : response channel (controller -> host)
// master = host, slave = controller.
interface reg_access_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  import reg_access_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/reg_access_ctrl.sv
// Initiator-side controller for a single-word register block. Accepts one
// host command at a time, sequences write/read strobes, captures read data
// after RD_LATENCY cycles and returns one response per command. WRITE_VERIFY
// writes, reads back and flags a mismatch. Counts handshaken responses and
// handshaken error responses (both wrap).
// Ports:
//   clk, reset                 : clock, async active-high reset
//   host (slave modport)       : cmd_* / rsp_* handshake channels
//   write_enable, write_data   : register write strobe and data
//   read_enable, read_data     : register read strobe and returned data
//   txn_count, err_count       : completion and error counters
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  reg_access_ctrl_if.slave    host,
  output logic                write_enable,
  output logic [WIDTH-1:0]    write_data,
  output logic                read_enable,
  input  logic [WIDTH-1:0]    read_data,
  output logic [CNT_W-1:0]    txn_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LATENCY - 1);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WAIT_W-1:0]  wait_cnt;

  // Controller FSM with registered strobes, response and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_q           <= OP_NOP;
      data_q         <= '0;
      wait_cnt       <= '0;
      host.cmd_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
      write_enable   <= 1'b0;
      write_data     <= '0;
      read_enable    <= 1'b0;
      txn_count      <= '0;
      err_count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // NOP is accepted and dropped: no strobe, no response.
          if (host.cmd_valid) begin
            op_q   <= host.cmd_op;
            data_q <= host.cmd_data;
            if (op_writes(host.cmd_op)) begin
              write_data     <= host.cmd_data;
              write_enable   <= 1'b1;
              host.cmd_ready <= 1'b0;
              state          <= ST_WR;
            end else if (host.cmd_op == OP_READ) begin
              read_enable    <= 1'b1;
              host.cmd_ready <= 1'b0;
              state          <= ST_RD;
            end
          end
        end

        ST_WR: begin
          write_enable <= 1'b0;
          if (op_q == OP_WRITE_VERIFY) begin
            // Read-back strobe follows the write strobe directly.
            read_enable <= 1'b1;
            state       <= ST_RD;
          end else begin
            host.rsp_data  <= '0;
            host.rsp_err   <= 1'b0;
            host.rsp_valid <= 1'b1;
            state          <= ST_RESP;
          end
        end

        ST_RD: begin
          read_enable <= 1'b0;
          wait_cnt    <= WAIT_LOAD;
          state       <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            host.rsp_data  <= read_data;
            host.rsp_err   <= (op_q == OP_WRITE_VERIFY) && (read_data != data_q);
            host.rsp_valid <= 1'b1;
            state          <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        ST_RESP: begin
          // Response fields hold until the host takes them.
          if (host.rsp_ready) begin
            host.rsp_valid <= 1'b0;
            host.cmd_ready <= 1'b1;
            txn_count      <= txn_count + CNT_W'(1);
            if (host.rsp_err) begin
              err_count <= err_count + CNT_W'(1);
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state          <= ST_IDLE;
          host.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
